// File: rtl/tdc_pkg.sv
// Shared types and helpers for the multi-channel time-to-digital converter.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating add clipped to w bits; bit 32 of the result flags saturation.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] full;
    logic [32:0] max;
    full = {1'b0, a} + {1'b0, b};
    max  = (33'(1) << w) - 33'(1);
    if (full > max) sat_add = {1'b1, max[31:0]};
    else            sat_add = {1'b0, full[31:0]};
  endfunction

endpackage

// File: rtl/tdc_chan.sv
// One TDC channel: synchroniser, edge detector, pulse counter, frame accumulator
// and a valid/ready output stage.
module tdc_chan
  import tdc_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [LEN_W-1:0] acc_len,
  input  logic             clr,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             miss
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [SYNC-1:0]  sync;
  logic             s;
  logic             s_d;
  state_t           state;
  logic [W-1:0]     cnt;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] pcnt;
  logic [LEN_W-1:0] len_q;

  logic             rise_c;
  logic [32:0]      sat_res_c;
  logic [ACC_W-1:0] acc_n_c;
  logic             acc_sat_c;
  logic [LEN_W:0]   pcnt_n_c;
  logic             last_c;
  logic [LEN_W-1:0] len_sel_c;

  assign s = sync[SYNC-1];

  // Next accumulator value and frame-completion decode for the MEAS exit.
  always_comb begin
    rise_c    = s & ~s_d;
    sat_res_c = sat_add(32'(acc), 32'(cnt), ACC_W);
    acc_n_c   = ACC_W'(sat_res_c);
    acc_sat_c = sat_res_c[32];
    pcnt_n_c  = {1'b0, pcnt} + (LEN_W+1)'(1);
    last_c    = pcnt_n_c >= {1'b0, len_q};
    len_sel_c = (acc_len == '0) ? LEN_W'(1) : acc_len;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '0;
      s_d       <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      pcnt      <= '0;
      len_q     <= LEN_W'(1);
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      // Synchroniser and edge history keep running through a flush.
      sync <= {sync[SYNC-2:0], in};
      s_d  <= s;
      if (clr) begin
        state     <= IDLE;
        cnt       <= '0;
        acc       <= '0;
        pcnt      <= '0;
        out       <= '0;
        out_valid <= 1'b0;
        ovf       <= 1'b0;
        miss      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_c) begin
              state <= MEAS;
              cnt   <= W'(1);
              if (pcnt == '0) len_q <= len_sel_c;
            end
          end
          MEAS: begin
            if (s) begin
              if (cnt == CNT_MAX) ovf <= 1'b1;
              else                cnt <= cnt + W'(1);
            end else begin
              acc  <= acc_n_c;
              pcnt <= LEN_W'(pcnt_n_c);
              if (acc_sat_c) ovf <= 1'b1;
              if (last_c) begin
                state     <= DONE;
                out       <= acc_n_c;
                out_valid <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          DONE: begin
            // A pulse arriving while the result is unconsumed is dropped.
            if (rise_c) miss <= 1'b1;
            if (out_ready) begin
              state     <= IDLE;
              acc       <= '0;
              pcnt      <= '0;
              ovf       <= 1'b0;
              out_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/tdc_mc.sv
// Multi-channel TDC top: CH independent channels sharing clock, reset, frame length and flush.
module tdc_mc
  import tdc_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       in,
  input  logic [LEN_W-1:0]    acc_len,
  input  logic                clr,
  output logic [CH*ACC_W-1:0] out,
  output logic [CH-1:0]       out_valid,
  input  logic [CH-1:0]       out_ready,
  output logic [CH-1:0]       ovf,
  output logic [CH-1:0]       miss
);

  for (genvar c = 0; c < CH; c++) begin : g_chan
    tdc_chan #(
      .W    (W),
      .ACC_W(ACC_W),
      .LEN_W(LEN_W),
      .SYNC (SYNC)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .in       (in[c]),
      .acc_len  (acc_len),
      .clr      (clr),
      .out      (out[c*ACC_W +: ACC_W]),
      .out_valid(out_valid[c]),
      .out_ready(out_ready[c]),
      .ovf      (ovf[c]),
      .miss     (miss[c])
    );
  end

endmodule

// File: tb/tb_tdc_mc.sv
// Directed self-checking bench for tdc_mc: a default 4-channel instance and a
// narrow single-channel instance for saturation cases.
module tb_tdc_mc;
  import tdc_pkg::*;

  localparam int unsigned CH    = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned ACC_W = 12;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned SYNC  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       in;
  logic [LEN_W-1:0]    acc_len;
  logic                clr;
  logic [CH*ACC_W-1:0] out;
  logic [CH-1:0]       out_valid;
  logic [CH-1:0]       out_ready;
  logic [CH-1:0]       ovf;
  logic [CH-1:0]       miss;

  logic                s_in;
  logic [LEN_W-1:0]    s_len;
  logic                s_clr;
  logic [4:0]          s_out;
  logic                s_valid;
  logic                s_ready;
  logic                s_ovf;
  logic                s_miss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdc_mc #(.CH(CH), .W(W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .in(in), .acc_len(acc_len), .clr(clr),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .miss(miss)
  );

  tdc_mc #(.CH(1), .W(4), .ACC_W(5), .LEN_W(LEN_W), .SYNC(SYNC)) dut_s (
    .clk(clk), .rst(rst), .in(s_in), .acc_len(s_len), .clr(s_clr),
    .out(s_out), .out_valid(s_valid), .out_ready(s_ready), .ovf(s_ovf), .miss(s_miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACC_W-1:0] ch_out(input int c);
    return out[c*ACC_W +: ACC_W];
  endfunction

  // Returns ticks until out_valid[c] rises, or -1 if the budget expires.
  task automatic wait_valid(input int c, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (out_valid[c]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_s_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (s_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse(input int c, input int len);
    in[c] = 1'b1;
    repeat (len) tick();
    in[c] = 1'b0;
  endtask

  task automatic accept(input logic [CH-1:0] mask);
    out_ready = mask;
    tick();
    out_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in = '1; acc_len = LEN_W'(1); clr = 1'b0; out_ready = '0;
    s_in = 1'b0; s_len = LEN_W'(1); s_clr = 1'b0; s_ready = 1'b0;
    repeat (4) tick();
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %0h expected 0", out); end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (ovf !== '0 || miss !== '0) begin errors++; $display("FAIL reset_flags: ovf %b miss %b expected 0", ovf, miss); end
    in = '0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single_pulse();
    int n;
    acc_len = LEN_W'(1);
    pulse(0, 5);
    wait_valid(0, 12, n);
    checks++; if (n != SYNC + 1) begin errors++; $display("FAIL single_latency: got %0d cycles expected %0d", (n < 0) ? n : n + 5, SYNC + 6); end
    checks++; if (ch_out(0) !== 12'd5) begin errors++; $display("FAIL single_out: got %0d expected 5", ch_out(0)); end
    checks++; if (ovf[0] !== 1'b0 || out_valid[3:1] !== 3'b000) begin errors++; $display("FAIL single_side: ovf %b valid %b expected 0/000", ovf[0], out_valid); end
    accept(4'b0001);
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL single_accept: valid got %b expected 0", out_valid[0]); end
  endtask

  task automatic test_accumulate();
    int n;
    acc_len = LEN_W'(3);
    pulse(1, 4);
    repeat (6) tick();
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL accum_early1: valid got 1 expected 0"); end
    acc_len = LEN_W'(1);
    pulse(1, 6);
    repeat (6) tick();
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL accum_early2: valid got 1 expected 0"); end
    pulse(1, 10);
    wait_valid(1, 12, n);
    checks++; if (n != SYNC + 1) begin errors++; $display("FAIL accum_latency: got %0d expected %0d", n, SYNC + 1); end
    checks++; if (ch_out(1) !== 12'd20) begin errors++; $display("FAIL accum_sum: got %0d expected 20", ch_out(1)); end
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL accum_ovf: got %b expected 0", ovf[1]); end
    accept(4'b0010);
    acc_len = LEN_W'(0);
    repeat (2) tick();
    pulse(2, 3);
    wait_valid(2, 12, n);
    checks++; if (n != SYNC + 1 || ch_out(2) !== 12'd3) begin errors++; $display("FAIL len_zero: latency %0d out %0d expected %0d/3", n, ch_out(2), SYNC + 1); end
    accept(4'b0100);
  endtask

  task automatic test_saturation();
    int n;
    s_len = LEN_W'(1);
    s_in = 1'b1;
    repeat (30) tick();
    s_in = 1'b0;
    wait_s_valid(12, n);
    checks++; if (n < 0 || s_out !== 5'd15) begin errors++; $display("FAIL sat_cnt_out: got %0d (wait %0d) expected 15", s_out, n); end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL sat_cnt_ovf: got %b expected 1", s_ovf); end
    s_ready = 1'b1; tick(); s_ready = 1'b0;
    checks++; if (s_ovf !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL sat_accept: ovf %b valid %b expected 0/0", s_ovf, s_valid); end
    s_len = LEN_W'(3);
    for (int p = 0; p < 3; p++) begin
      s_in = 1'b1;
      repeat (15) tick();
      s_in = 1'b0;
      if (p < 2) repeat (6) tick();
    end
    wait_s_valid(12, n);
    checks++; if (n < 0 || s_out !== 5'd31) begin errors++; $display("FAIL sat_acc_out: got %0d (wait %0d) expected 31", s_out, n); end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL sat_acc_ovf: got %b expected 1", s_ovf); end
    s_ready = 1'b1; tick(); s_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    acc_len = LEN_W'(1);
    pulse(0, 5);
    wait_valid(0, 12, n);
    checks++; if (n < 0 || ch_out(0) !== 12'd5) begin errors++; $display("FAIL bp_first: got %0d (wait %0d) expected 5", ch_out(0), n); end
    pulse(0, 3);
    repeat (8) tick();
    checks++; if (out_valid[0] !== 1'b1 || ch_out(0) !== 12'd5) begin errors++; $display("FAIL bp_hold: valid %b out %0d expected 1/5", out_valid[0], ch_out(0)); end
    checks++; if (miss[0] !== 1'b1) begin errors++; $display("FAIL bp_miss: got %b expected 1", miss[0]); end
    accept(4'b0001);
    checks++; if (out_valid[0] !== 1'b0 || miss[0] !== 1'b1) begin errors++; $display("FAIL bp_accept: valid %b miss %b expected 0/1", out_valid[0], miss[0]); end
    repeat (2) tick();
    pulse(0, 7);
    wait_valid(0, 12, n);
    checks++; if (n != SYNC + 1 || ch_out(0) !== 12'd7) begin errors++; $display("FAIL bp_next: latency %0d out %0d expected %0d/7", n, ch_out(0), SYNC + 1); end
    accept(4'b0001);
  endtask

  task automatic test_independence();
    int lens[4] = '{3, 7, 2, 9};
    acc_len = LEN_W'(1);
    repeat (2) tick();
    in = '1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      for (int c = 0; c < 4; c++) if (k == lens[c]) in[c] = 1'b0;
    end
    repeat (SYNC + 2) tick();
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL indep_valid: got %b expected 1111", out_valid); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ch_out(c) !== 12'(lens[c])) begin errors++; $display("FAIL indep_out%0d: got %0d expected %0d", c, ch_out(c), lens[c]); end
    end
    accept(4'b0010);
    checks++; if (out_valid !== 4'b1101 || ch_out(0) !== 12'd3) begin errors++; $display("FAIL indep_acc1: valid %b out0 %0d expected 1101/3", out_valid, ch_out(0)); end
    accept(4'b1000);
    checks++; if (out_valid !== 4'b0101) begin errors++; $display("FAIL indep_acc3: got %b expected 0101", out_valid); end
    accept(4'b0101);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL indep_acc_all: got %b expected 0000", out_valid); end
  endtask

  task automatic test_clear();
    acc_len = LEN_W'(1);
    in[2] = 1'b1;
    repeat (SYNC + 3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (out !== '0 || out_valid !== '0) begin errors++; $display("FAIL clr_out: out %0h valid %b expected 0/0", out, out_valid); end
    checks++; if (miss !== '0 || ovf !== '0) begin errors++; $display("FAIL clr_flags: miss %b ovf %b expected 0/0", miss, ovf); end
    repeat (3) tick();
    in[2] = 1'b0;
    repeat (SYNC + 4) tick();
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL clr_partial: valid %b expected 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int n;
    acc_len = LEN_W'(1);
    pulse(3, 4);
    wait_valid(3, 12, n);
    checks++; if (n < 0 || ch_out(3) !== 12'd4) begin errors++; $display("FAIL rst_pre: out %0d (wait %0d) expected 4", ch_out(3), n); end
    in[0] = 1'b1;
    repeat (SYNC + 3) tick();
    rst = 1'b0;
    #1;
    checks++; if (out !== '0 || out_valid !== '0) begin errors++; $display("FAIL rst_mid: out %0h valid %b expected 0/0", out, out_valid); end
    in[0] = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    pulse(0, 5);
    wait_valid(0, 12, n);
    checks++; if (n != SYNC + 1 || ch_out(0) !== 12'd5) begin errors++; $display("FAIL rst_fresh: latency %0d out %0d expected %0d/5", n, ch_out(0), SYNC + 1); end
    accept(4'b0001);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_accumulate();
    test_saturation();
    test_backpressure();
    test_independence();
    test_clear();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
